// File: rtl/vga_rect_scheduler.sv
// Four-slot rectangle overlay for a 640x480 raster: arbitrated descriptor writes, frame-synchronous commit, registered pixel colour.
// Build option: define VGA_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module vga_rect_scheduler #(
    parameter int         N_REQ    = 2,
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic [9:0]            x_pos,
    input  logic [9:0]            y_pos,
    input  logic                  frame_start,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*46-1:0]   req_desc,
    output logic [N_REQ-1:0]      gnt,
    output logic [2:0]            rgb_out,
    output logic                  frame_commit
);

    localparam int         DESC_W = 46;
    localparam int         BODY_W = 44;
    localparam int         NSLOT  = 4;
    localparam int         IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COOL
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    win_idx;
    logic [DESC_W-1:0]   win_desc;
    logic [1:0]          win_slot;
    logic [BODY_W-1:0]   pend_data [NSLOT];
    logic [NSLOT-1:0]    pend_valid;
    logic [BODY_W-1:0]   act_data  [NSLOT];
    logic                commit;
    logic [NSLOT-1:0]    slot_hit;
    logic [2:0]          pix_rgb;

    assign win_slot = win_desc[45:44];
    assign commit   = frame_start & pix_en;

`ifdef VGA_FIXED_PRIO_EN
    // Lowest requesting index always wins.
    always_comb begin
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    logic             rr_found;
    int               rr_cand;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        pick_idx = rr_ptr;
        rr_found = 1'b0;
        rr_cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_cand = (int'(rr_ptr) + i) % N_REQ;
            if (!rr_found && req[rr_cand]) begin
                pick_idx = IDX_W'(rr_cand);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == GRANT) begin
            rr_ptr <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        gnt        = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    next_state = GRANT;
                end
            end
            GRANT: begin
                gnt[win_idx] = 1'b1;
                next_state   = COOL;
            end
            COOL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Winner and its descriptor are captured on leaving IDLE so gnt and the write refer to the same request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_idx  <= '0;
            win_desc <= '0;
        end else if (state == IDLE && (|req)) begin
            win_idx  <= pick_idx;
            win_desc <= req_desc[int'(pick_idx)*DESC_W +: DESC_W];
        end
    end

    // A GRANT write is placed after the commit clear so that a colliding write stays pending for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSLOT; s++) begin
                pend_data[s] <= '0;
                act_data[s]  <= '0;
            end
            pend_valid   <= '0;
            frame_commit <= 1'b0;
        end else begin
            frame_commit <= commit & (|pend_valid);
            for (int s = 0; s < NSLOT; s++) begin
                if (commit && pend_valid[s]) begin
                    act_data[s]   <= pend_data[s];
                    pend_valid[s] <= 1'b0;
                end
            end
            if (state == GRANT) begin
                pend_data[win_slot]  <= win_desc[BODY_W-1:0];
                pend_valid[win_slot] <= 1'b1;
            end
        end
    end

    // Inclusive bounds; an inverted range simply never matches.
    always_comb begin
        for (int s = 0; s < NSLOT; s++) begin
            slot_hit[s] = act_data[s][43]
                        && (x_pos >= act_data[s][42:33]) && (x_pos <= act_data[s][32:23])
                        && (y_pos >= act_data[s][22:13]) && (y_pos <= act_data[s][12:3]);
        end
    end

    always_comb begin
        pix_rgb = BG_COLOR;
        for (int s = NSLOT - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                pix_rgb = act_data[s][2:0];
            end
        end
        if (x_pos >= H_LIM || y_pos >= V_LIM) begin
            pix_rgb = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out <= 3'b000;
        end else if (pix_en) begin
            rgb_out <= pix_rgb;
        end
    end

endmodule
